// File: rtl/axi_mem_responder_if.sv
// AXI4 subset bus between a kernel read/write master and the memory responder.
// Widths must match the parameters of the axi_mem_responder instance it is bound to.
interface axi_mem_responder_if #(
    parameter int unsigned C_ADDR_WIDTH = 64,
    parameter int unsigned C_DATA_WIDTH = 512
);
    logic                      s_axi_awvalid;
    logic                      s_axi_awready;
    logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [7:0]                s_axi_awlen;
    logic                      s_axi_wvalid;
    logic                      s_axi_wready;
    logic [C_DATA_WIDTH-1:0]   s_axi_wdata;
    logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                      s_axi_wlast;
    logic                      s_axi_bvalid;
    logic                      s_axi_bready;
    logic                      s_axi_arvalid;
    logic                      s_axi_arready;
    logic [C_ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [7:0]                s_axi_arlen;
    logic                      s_axi_rvalid;
    logic                      s_axi_rready;
    logic [C_DATA_WIDTH-1:0]   s_axi_rdata;
    logic                      s_axi_rlast;

    modport slave (
        input  s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
        output s_axi_awready,
        input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
        output s_axi_wready,
        output s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arvalid, s_axi_araddr, s_axi_arlen,
        output s_axi_arready,
        output s_axi_rvalid, s_axi_rdata, s_axi_rlast,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
        input  s_axi_awready,
        output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
        input  s_axi_wready,
        input  s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arvalid, s_axi_araddr, s_axi_arlen,
        input  s_axi_arready,
        input  s_axi_rvalid, s_axi_rdata, s_axi_rlast,
        output s_axi_rready
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: INCR bursts on independent read and write channels into an
// on-chip word array. Byte strobes honoured, one OKAY response per write burst.
// All bus outputs come straight from registers.
module axi_mem_responder #(
    parameter int unsigned C_ADDR_WIDTH = 64,
    parameter int unsigned C_DATA_WIDTH = 512,
    parameter int unsigned C_MEM_DEPTH  = 1024
) (
    input  logic               aclk,
    input  logic               areset,
    axi_mem_responder_if.slave s_axi,
    output logic               err_wlast
);
    localparam int unsigned StrbW = C_DATA_WIDTH / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned IdxW  = $clog2(C_MEM_DEPTH);

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;

    // Word array; deliberately not reset.
    logic [C_DATA_WIDTH-1:0] r_mem [C_MEM_DEPTH];

    w_state_e            r_wstate;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic [IdxW-1:0]     r_widx;
    logic [7:0]          r_wlen;
    logic [7:0]          r_wcnt;
    logic                r_err_wlast;

    r_state_e            r_rstate;
    logic                r_arready;
    logic                r_rvalid;
    logic                r_rlast;
    logic [C_DATA_WIDTH-1:0] r_rdata;
    logic [IdxW-1:0]     r_ridx;
    logic [7:0]          r_rlen;
    logic [7:0]          r_rcnt;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic [IdxW-1:0]     w_aw_idx;
    logic [IdxW-1:0]     w_ar_idx;
    logic                w_unused_addr;

    assign w_aw_hs  = s_axi.s_axi_awvalid & r_awready;
    assign w_w_hs   = s_axi.s_axi_wvalid  & r_wready;
    assign w_b_hs   = r_bvalid & s_axi.s_axi_bready;
    assign w_ar_hs  = s_axi.s_axi_arvalid & r_arready;
    assign w_r_hs   = r_rvalid & s_axi.s_axi_rready;

    // Byte offset and upper address bits are ignored, so addresses alias modulo the array.
    assign w_aw_idx = s_axi.s_axi_awaddr[OffW +: IdxW];
    assign w_ar_idx = s_axi.s_axi_araddr[OffW +: IdxW];
    assign w_unused_addr = ^{s_axi.s_axi_awaddr, s_axi.s_axi_araddr};

    assign s_axi.s_axi_awready = r_awready;
    assign s_axi.s_axi_wready  = r_wready;
    assign s_axi.s_axi_bvalid  = r_bvalid;
    assign s_axi.s_axi_arready = r_arready;
    assign s_axi.s_axi_rvalid  = r_rvalid;
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rlast   = r_rlast;
    assign err_wlast           = r_err_wlast;

    // Write FSM: accept AW, take awlen+1 beats, then hold the B response until bready.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wstate    <= WIdle;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_widx      <= '0;
            r_wlen      <= 8'd0;
            r_wcnt      <= 8'd0;
            r_err_wlast <= 1'b0;
        end else begin
            unique case (r_wstate)
                WIdle: begin
                    if (w_aw_hs) begin
                        r_widx    <= w_aw_idx;
                        r_wlen    <= s_axi.s_axi_awlen;
                        r_wcnt    <= 8'd0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= WData;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                WData: begin
                    if (w_w_hs) begin
                        r_widx <= r_widx + 1'b1;
                        r_wcnt <= r_wcnt + 8'd1;
                        // Burst length comes from awlen; wlast is only cross-checked.
                        if (r_wcnt == r_wlen) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_wstate <= WResp;
                            if (!s_axi.s_axi_wlast) begin
                                r_err_wlast <= 1'b1;
                            end
                        end else if (s_axi.s_axi_wlast) begin
                            r_err_wlast <= 1'b1;
                        end
                    end
                end
                WResp: begin
                    if (w_b_hs) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= WIdle;
                    end
                end
                default: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_wstate  <= WIdle;
                end
            endcase
        end
    end

    // Array write port: strobed byte merge; a beat on the reset edge is dropped.
    always_ff @(posedge aclk) begin
        if (w_w_hs && !areset) begin
            for (int unsigned b = 0; b < StrbW; b++) begin
                if (s_axi.s_axi_wstrb[b]) begin
                    r_mem[r_widx][b*8 +: 8] <= s_axi.s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM: the array read for the next beat is issued on each R handshake, so beats
    // stream without bubbles; a same-edge write is not visible (read-first).
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rstate  <= RIdle;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_ridx    <= '0;
            r_rlen    <= 8'd0;
            r_rcnt    <= 8'd0;
        end else begin
            unique case (r_rstate)
                RIdle: begin
                    if (w_ar_hs) begin
                        r_ridx    <= w_ar_idx;
                        r_rlen    <= s_axi.s_axi_arlen;
                        r_arready <= 1'b0;
                        r_rstate  <= RFetch;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                RFetch: begin
                    r_rdata  <= r_mem[r_ridx];
                    r_ridx   <= r_ridx + 1'b1;
                    r_rcnt   <= 8'd0;
                    r_rvalid <= 1'b1;
                    r_rlast  <= (r_rlen == 8'd0);
                    r_rstate <= RData;
                end
                RData: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= RIdle;
                        end else begin
                            r_rdata <= r_mem[r_ridx];
                            r_ridx  <= r_ridx + 1'b1;
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                        end
                    end
                end
                default: begin
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                    r_rstate  <= RIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: bus-level write/read bursts against a byte-merging
// reference memory, with a queue of expected read beats.
module tb_axi_mem_responder;
    localparam int unsigned AW    = 64;
    localparam int unsigned DW    = 512;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned OFFW  = $clog2(SW);
    localparam int unsigned IDXW  = $clog2(DEPTH);

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic err_wlast;

    axi_mem_responder_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) axi ();

    axi_mem_responder #(
        .C_ADDR_WIDTH(AW),
        .C_DATA_WIDTH(DW),
        .C_MEM_DEPTH (DEPTH)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_axi    (axi),
        .err_wlast(err_wlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] wbuf  [256];
    logic [SW-1:0] sbuf  [256];
    int            n_chk = 0;
    int            n_err = 0;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic int unsigned idx_of(input logic [AW-1:0] a);
        return 32'(a[OFFW +: IDXW]);
    endfunction

    // Drives one write burst from wbuf/sbuf and updates the reference memory per beat.
    task automatic write_burst(input logic [AW-1:0] addr, input int len, input int wlast_beat,
                               input bit stall, output bit aw_wready, output int b_delay);
        int n;
        int gap;
        int unsigned base;
        int unsigned wi;
        base = idx_of(addr);
        aw_wready = 1'b0;
        b_delay = -1;
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_awaddr  = addr;
        axi.s_axi_awlen   = 8'(len);
        n = 0;
        while (axi.s_axi_awready !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            n_chk++; n_err++;
            $display("FAIL aw_timeout: awready=%b required 1", axi.s_axi_awready);
            axi.s_axi_awvalid = 1'b0;
            return;
        end
        tick();
        axi.s_axi_awvalid = 1'b0;
        aw_wready = (axi.s_axi_wready === 1'b1);
        for (int beat = 0; beat <= len; beat++) begin
            if (stall) begin
                gap = int'($urandom_range(0, 2));
                repeat (gap) tick();
            end
            axi.s_axi_wvalid = 1'b1;
            axi.s_axi_wdata  = wbuf[beat];
            axi.s_axi_wstrb  = sbuf[beat];
            axi.s_axi_wlast  = (beat == wlast_beat);
            n = 0;
            while (axi.s_axi_wready !== 1'b1 && n < 100) begin tick(); n++; end
            if (n >= 100) begin
                n_chk++; n_err++;
                $display("FAIL w_timeout beat %0d: wready=%b required 1", beat, axi.s_axi_wready);
                axi.s_axi_wvalid = 1'b0;
                axi.s_axi_wlast  = 1'b0;
                return;
            end
            tick();
            wi = (base + 32'(beat)) % DEPTH;
            for (int b = 0; b < int'(SW); b++) begin
                if (sbuf[beat][b]) m_mem[wi][b*8 +: 8] = wbuf[beat][b*8 +: 8];
            end
            axi.s_axi_wvalid = 1'b0;
            axi.s_axi_wlast  = 1'b0;
        end
        n = 0;
        while (axi.s_axi_bvalid !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            n_chk++; n_err++;
            $display("FAIL b_timeout: bvalid=%b required 1", axi.s_axi_bvalid);
            return;
        end
        b_delay = n;
        axi.s_axi_bready = 1'b1;
        tick();
        axi.s_axi_bready = 1'b0;
    endtask

    // Issues one read burst, pushes expected beats, then pops/compares each R handshake.
    task automatic read_burst(input logic [AW-1:0] addr, input int len, input bit stall,
                              output int first_lat, output int cyc,
                              output logic [DW-1:0] last_data);
        int n;
        int got;
        bit rr;
        bit held;
        logic [DW-1:0] held_data;
        logic held_last;
        int unsigned base;
        exp_t e;
        base = idx_of(addr);
        first_lat = -1;
        cyc = 0;
        last_data = '0;
        for (int b = 0; b <= len; b++) begin
            e.data = m_mem[(base + 32'(b)) % DEPTH];
            e.last = (b == len);
            exp_q.push_back(e);
        end
        axi.s_axi_rready  = 1'b0;
        axi.s_axi_arvalid = 1'b1;
        axi.s_axi_araddr  = addr;
        axi.s_axi_arlen   = 8'(len);
        n = 0;
        while (axi.s_axi_arready !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            n_chk++; n_err++;
            $display("FAIL ar_timeout: arready=%b required 1", axi.s_axi_arready);
            axi.s_axi_arvalid = 1'b0;
            exp_q.delete();
            return;
        end
        tick();
        axi.s_axi_arvalid = 1'b0;
        got = 0;
        held = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        while (got <= len && cyc < 2000) begin
            rr = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            axi.s_axi_rready = rr;
            if (axi.s_axi_rvalid === 1'b1) begin
                if (first_lat < 0) first_lat = cyc + 1;
                if (held) begin
                    n_chk++;
                    if (axi.s_axi_rdata !== held_data || axi.s_axi_rlast !== held_last) begin
                        n_err++;
                        $display("FAIL r_stable beat %0d: rdata=%h rlast=%b required rdata=%h rlast=%b",
                                 got, axi.s_axi_rdata, axi.s_axi_rlast, held_data, held_last);
                    end
                end
                if (rr) begin
                    e = exp_q.pop_front();
                    n_chk++;
                    if (axi.s_axi_rdata !== e.data || axi.s_axi_rlast !== e.last) begin
                        n_err++;
                        $display("FAIL r_beat %0d: rdata=%h rlast=%b required rdata=%h rlast=%b",
                                 got, axi.s_axi_rdata, axi.s_axi_rlast, e.data, e.last);
                    end
                    last_data = axi.s_axi_rdata;
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_data = axi.s_axi_rdata;
                    held_last = axi.s_axi_rlast;
                end
            end
            tick();
            cyc++;
        end
        axi.s_axi_rready = 1'b0;
        if (got <= len) begin
            n_chk++; n_err++;
            $display("FAIL r_timeout: beats=%0d required %0d", got, len + 1);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        axi.s_axi_awvalid = 1'b0; axi.s_axi_awaddr = '0; axi.s_axi_awlen = 8'd0;
        axi.s_axi_wvalid  = 1'b0; axi.s_axi_wdata  = '0; axi.s_axi_wstrb = '0;
        axi.s_axi_wlast   = 1'b0; axi.s_axi_bready = 1'b0;
        axi.s_axi_arvalid = 1'b0; axi.s_axi_araddr = '0; axi.s_axi_arlen = 8'd0;
        axi.s_axi_rready  = 1'b0;
        areset = 1'b1;
        repeat (3) tick();
        n_chk++;
        if ({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid, axi.s_axi_arready,
             axi.s_axi_rvalid, axi.s_axi_rlast, err_wlast} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: aw/w/b/ar/rv/rl/err=%b%b%b%b%b%b%b required 0000000",
                     axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid, axi.s_axi_arready,
                     axi.s_axi_rvalid, axi.s_axi_rlast, err_wlast);
        end
        n_chk++;
        if (axi.s_axi_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_rdata: rdata=%h required 0", axi.s_axi_rdata);
        end
        areset = 1'b0;
        n_chk++;
        if (axi.s_axi_awready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_early_ready: awready=%b required 0", axi.s_axi_awready);
        end
        tick();
        n_chk++;
        if (axi.s_axi_awready !== 1'b1 || axi.s_axi_arready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: awready=%b arready=%b required 1 1",
                     axi.s_axi_awready, axi.s_axi_arready);
        end
    endtask

    task automatic test_single_beat();
        bit awr;
        int bd, lat, cyc;
        logic [DW-1:0] ld;
        wbuf[0] = {SW{8'hA5}};
        sbuf[0] = '1;
        write_burst(64'h40, 0, 0, 1'b0, awr, bd);
        n_chk++;
        if (awr !== 1'b1) begin
            n_err++; $display("FAIL single_wready: wready after AW=%b required 1", awr);
        end
        n_chk++;
        if (bd != 0) begin
            n_err++; $display("FAIL single_bvalid_delay: extra cycles=%0d required 0", bd);
        end
        read_burst(64'h40, 0, 1'b0, lat, cyc, ld);
        n_chk++;
        if (lat != 2 || cyc != 2) begin
            n_err++; $display("FAIL single_read_timing: lat=%0d done=%0d required 2 2", lat, cyc);
        end
        n_chk++;
        if (ld !== {SW{8'hA5}}) begin
            n_err++; $display("FAIL single_rdata: rdata=%h required A5 pattern", ld);
        end
        n_chk++;
        if (err_wlast !== 1'b0) begin
            n_err++; $display("FAIL single_err: err_wlast=%b required 0", err_wlast);
        end
    endtask

    task automatic test_burst16();
        bit awr;
        int bd, lat, cyc;
        logic [DW-1:0] ld;
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = DW'(i);
            sbuf[i] = '1;
        end
        write_burst(64'h1000, 15, 15, 1'b1, awr, bd);
        read_burst(64'h1000, 15, 1'b1, lat, cyc, ld);
        read_burst(64'h1000, 15, 1'b0, lat, cyc, ld);
        n_chk++;
        if (lat != 2 || cyc != 17) begin
            n_err++; $display("FAIL burst16_stream: lat=%0d done=%0d required 2 17", lat, cyc);
        end
        n_chk++;
        if (ld !== DW'(15)) begin
            n_err++; $display("FAIL burst16_last: rdata=%h required 15", ld);
        end
    endtask

    task automatic test_strobe();
        bit awr;
        int bd, lat, cyc;
        logic [DW-1:0] ld;
        wbuf[0] = '1;
        sbuf[0] = '1;
        write_burst(64'h3000, 0, 0, 1'b0, awr, bd);
        wbuf[0] = '0;
        sbuf[0] = '0;
        sbuf[0][3:0] = 4'hF;
        write_burst(64'h3000, 0, 0, 1'b0, awr, bd);
        read_burst(64'h3000, 0, 1'b0, lat, cyc, ld);
        n_chk++;
        if (ld !== {{(SW-4){8'hFF}}, 32'h0}) begin
            n_err++; $display("FAIL strobe_merge: rdata=%h required FF..FF00000000", ld);
        end
    endtask

    task automatic test_wrap();
        bit awr;
        int bd, lat, cyc;
        logic [DW-1:0] ld;
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = {(DW/32){32'hBEEF0000 + 32'(i)}};
            sbuf[i] = '1;
        end
        write_burst(64'((DEPTH - 2) * SW), 3, 3, 1'b0, awr, bd);
        read_burst(64'((DEPTH - 2) * SW), 0, 1'b0, lat, cyc, ld);
        read_burst(64'((DEPTH - 1) * SW), 0, 1'b0, lat, cyc, ld);
        // Word 0 through an aliased address with a nonzero byte offset.
        read_burst(64'h1_0005, 0, 1'b0, lat, cyc, ld);
        n_chk++;
        if (ld !== {(DW/32){32'hBEEF0002}}) begin
            n_err++; $display("FAIL wrap_word0: rdata=%h required BEEF0002 pattern", ld);
        end
        read_burst(64'(SW), 0, 1'b0, lat, cyc, ld);
        n_chk++;
        if (ld !== {(DW/32){32'hBEEF0003}}) begin
            n_err++; $display("FAIL wrap_word1: rdata=%h required BEEF0003 pattern", ld);
        end
    endtask

    task automatic test_wlast_err();
        bit awr;
        int bd, lat, cyc, extra_b;
        logic [DW-1:0] ld;
        n_chk++;
        if (err_wlast !== 1'b0) begin
            n_err++; $display("FAIL wlast_pre: err_wlast=%b required 0", err_wlast);
        end
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = {(DW/32){32'h5A5A0000 + 32'(i)}};
            sbuf[i] = '1;
        end
        write_burst(64'h5000, 3, 1, 1'b0, awr, bd);
        n_chk++;
        if (axi.s_axi_wready !== 1'b0 || axi.s_axi_bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL wlast_after_b: wready=%b bvalid=%b required 0 0",
                     axi.s_axi_wready, axi.s_axi_bvalid);
        end
        extra_b = 0;
        axi.s_axi_bready = 1'b1;
        repeat (4) begin
            if (axi.s_axi_bvalid === 1'b1) extra_b++;
            tick();
        end
        axi.s_axi_bready = 1'b0;
        n_chk++;
        if (extra_b != 0) begin
            n_err++; $display("FAIL wlast_one_b: extra bvalid cycles=%0d required 0", extra_b);
        end
        n_chk++;
        if (err_wlast !== 1'b1) begin
            n_err++; $display("FAIL wlast_flag: err_wlast=%b required 1", err_wlast);
        end
        read_burst(64'h5000, 3, 1'b0, lat, cyc, ld);
        wbuf[0] = {SW{8'h3C}};
        sbuf[0] = '1;
        write_burst(64'h6000, 0, 0, 1'b0, awr, bd);
        n_chk++;
        if (err_wlast !== 1'b1) begin
            n_err++; $display("FAIL wlast_sticky: err_wlast=%b required 1", err_wlast);
        end
    endtask

    task automatic test_reset_mid_read();
        bit awr;
        int bd, lat, cyc, n, got;
        logic [DW-1:0] ld;
        int unsigned base;
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = {(DW/32){32'hC0DE0000 + 32'(i)}};
            sbuf[i] = '1;
        end
        write_burst(64'h2000, 7, 7, 1'b0, awr, bd);
        base = idx_of(64'h2000);
        axi.s_axi_araddr  = 64'h2000;
        axi.s_axi_arlen   = 8'd7;
        axi.s_axi_arvalid = 1'b1;
        n = 0;
        while (axi.s_axi_arready !== 1'b1 && n < 100) begin tick(); n++; end
        tick();
        axi.s_axi_arvalid = 1'b0;
        axi.s_axi_rready  = 1'b1;
        got = 0;
        n = 0;
        while (got < 2 && n < 100) begin
            if (axi.s_axi_rvalid === 1'b1) got++;
            tick();
            n++;
        end
        n_chk++;
        if (axi.s_axi_rvalid !== 1'b1 || axi.s_axi_rdata !== m_mem[base + 2]) begin
            n_err++;
            $display("FAIL midread_beat3: rvalid=%b rdata=%h required 1 %h",
                     axi.s_axi_rvalid, axi.s_axi_rdata, m_mem[base + 2]);
        end
        areset = 1'b1;
        tick();
        n_chk++;
        if (axi.s_axi_rvalid !== 1'b0 || axi.s_axi_rlast !== 1'b0 || axi.s_axi_rdata !== '0) begin
            n_err++;
            $display("FAIL midread_abort: rvalid=%b rlast=%b rdata=%h required 0 0 0",
                     axi.s_axi_rvalid, axi.s_axi_rlast, axi.s_axi_rdata);
        end
        n_chk++;
        if (err_wlast !== 1'b0) begin
            n_err++; $display("FAIL midread_err_clear: err_wlast=%b required 0", err_wlast);
        end
        areset = 1'b0;
        axi.s_axi_rready = 1'b0;
        n_chk++;
        if (axi.s_axi_arready !== 1'b0) begin
            n_err++; $display("FAIL midread_ready_early: arready=%b required 0", axi.s_axi_arready);
        end
        tick();
        n_chk++;
        if (axi.s_axi_arready !== 1'b1) begin
            n_err++; $display("FAIL midread_ready: arready=%b required 1", axi.s_axi_arready);
        end
        read_burst(64'h2000, 7, 1'b0, lat, cyc, ld);
        n_chk++;
        if (lat != 2 || cyc != 9) begin
            n_err++; $display("FAIL midread_reread: lat=%0d done=%0d required 2 9", lat, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst16();
        test_strobe();
        test_wrap();
        test_wlast_err();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
